eth_frame_arbiter: RTL
======================

ETH_FRAME_ARBITER -- requirements
Module: eth_frame_arbiter

Interface
REQ-001 SHALL have parameter N_PORTS, default 4, number of ingress requesters (2..16).
REQ-002 SHALL have parameter MAX_FRAME_BYTES, default 1526, maximum bytes per forwarded frame (DMAC+SMAC+2 QTAGs+Ethertype+1500 MTU+FCS).
REQ-003 SHALL have parameter IFG_CYCLES, default 12, idle cycles inserted after each frame (0 allowed).
REQ-004 SHALL have clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have in_valid  input  N_PORTS  per-port byte valid.
REQ-007 SHALL have in_data  input  8*N_PORTS  per-port byte; port i at bits [8i+7:8i].
REQ-008 SHALL have in_last  input  N_PORTS  per-port last byte of frame.
REQ-009 SHALL have in_ready  output  N_PORTS  per-port byte accepted when valid&ready.
REQ-010 SHALL have out_valid/out_data/out_last  output  1/8/1  egress byte stream.
REQ-011 SHALL have out_ready  input  1  egress backpressure.
REQ-012 SHALL have grant_id  output  $clog2(N_PORTS)  currently granted port.
REQ-013 SHALL have trunc_pulse  output  1  one-cycle flag on oversize-frame truncation.

Function
REQ-014 SHALL implement FSM states IDLE, XFER, DROP, GAP.
REQ-015 IDLE: SHALL select, when any in_valid set, the first requesting port in round-robin order starting at (last granted + 1) mod N_PORTS, register it into grant_id, clear byte counter, enter XFER next cycle; one idle cycle arbitration latency.
REQ-016 IDLE: SHALL hold all in_ready=0 and out_valid=0.
REQ-017 XFER: out_valid=in_valid[g], out_data=in_data[g], out_last=in_last[g] or truncation, in_ready[g]=out_ready, in_ready of other ports 0; combinational, zero latency.
REQ-018 XFER: grant SHALL be held for the whole frame; no re-arbitration until in_last[g] accepted or truncation.
REQ-019 Byte counter (width $clog2(MAX_FRAME_BYTES+1)) SHALL increment on each egress handshake in XFER; no wrap possible.
REQ-020 On accepted byte with in_last[g]=1: SHALL enter GAP (or IDLE if IFG_CYCLES=0).
REQ-021 On accepted byte number MAX_FRAME_BYTES with in_last[g]=0: SHALL force out_last=1 on that byte, pulse trunc_pulse next cycle, enter DROP.
REQ-022 Byte MAX_FRAME_BYTES with in_last=1 SHALL be a normal frame, no truncation.
REQ-023 DROP: in_ready[g]=1, out_valid=0, discard bytes until in_last[g] accepted, then GAP/IDLE per REQ-020.
REQ-024 GAP: SHALL count IFG_CYCLES cycles with all in_ready=0, out_valid=0, then IDLE; counter not advanced by out_ready.
REQ-025 Round-robin pointer SHALL update only on grant; a port requesting alone SHALL be regranted after every GAP.
REQ-026 in_valid deasserted mid-frame SHALL stall XFER (no timeout); out_valid follows.
REQ-027 out_data SHALL be 0 whenever out_valid=0.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force IDLE, grant_id=0, RR pointer so port 0 is first priority, counters 0, trunc_pulse=0, all in_ready=0, out_valid=0, out_last=0.
REQ-029 Reset mid-frame SHALL abandon the frame without emitting out_last; first post-reset grant follows REQ-015.

Verification
REQ-030 Ports 1 and 3 request simultaneously after reset, 64-byte frames -> port 1 granted first, 12 idle cycles, then port 3, then port 1; no interleaving.
REQ-031 Single port, 1526-byte frame with last on byte 1526 -> forwarded intact, trunc_pulse never set.
REQ-032 Single port, 1600-byte frame -> 1526 bytes out, out_last on byte 1526, one trunc_pulse, remaining 74 bytes consumed with out_valid=0, then GAP.
REQ-033 out_ready toggled 50% randomly during 100-byte frame -> every byte exactly once in order, in_ready[g] equals out_ready each XFER cycle.
REQ-034 rst_n low for one cycle at byte 30 of a frame -> outputs at reset values next cycle; new frame from any port forwarded normally.
REQ-035 IFG_CYCLES=0, all four ports continuously requesting 1-byte frames -> grants 0,1,2,3,0 with one IDLE cycle between frames.

Source files
------------

// File: rtl/eth_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : eth_frame_arbiter
// Description : Round-robin N-port Ethernet frame arbiter with oversize-frame
//               truncation and inter-frame gap insertion.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_frame_arbiter #(
    parameter int N_PORTS         = 4,
    parameter int MAX_FRAME_BYTES = 1526,
    parameter int IFG_CYCLES      = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_PORTS-1:0]         in_valid,
    input  logic [8*N_PORTS-1:0]       in_data,
    input  logic [N_PORTS-1:0]         in_last,
    output logic [N_PORTS-1:0]         in_ready,
    output logic                       out_valid,
    output logic [7:0]                 out_data,
    output logic                       out_last,
    input  logic                       out_ready,
    output logic [$clog2(N_PORTS)-1:0] grant_id,
    output logic                       trunc_pulse
);

    localparam int c_GW = $clog2(N_PORTS);
    localparam int c_IW = c_GW + 1;
    localparam int c_CW = $clog2(MAX_FRAME_BYTES + 1);
    localparam int c_TW = $clog2(IFG_CYCLES + 2);
    localparam logic [c_CW-1:0] c_LAST_BYTE = c_CW'(MAX_FRAME_BYTES - 1);
    localparam logic [c_TW-1:0] c_GAP_END   = c_TW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;
    localparam logic [1:0] c_POST = (IFG_CYCLES > 0) ? S_GAP : S_IDLE;

    logic [1:0]      r_state, w_state_nxt;
    logic [c_GW-1:0] r_grant, r_rr_ptr, w_sel, w_ptr_nxt;
    logic [c_IW-1:0] w_idx;
    logic            w_found;
    logic [c_CW-1:0] r_cnt;
    logic [c_TW-1:0] r_gap;
    logic            r_trunc;
    logic            w_g_valid, w_g_last;
    logic [7:0]      w_g_data;
    logic            w_hs, w_at_max, w_trunc, w_drop_end;

    always_comb begin
        w_g_valid = 1'b0;
        w_g_last  = 1'b0;
        w_g_data  = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (r_grant == c_GW'(i)) begin
                w_g_valid = in_valid[i];
                w_g_last  = in_last[i];
                w_g_data  = in_data[8*i +: 8];
            end
        end
    end

    // Scan downward so the requester closest to the pointer is written last and wins.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_rr_ptr;
        w_idx   = '0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            w_idx = {1'b0, r_rr_ptr} + c_IW'(i);
            if (w_idx >= c_IW'(N_PORTS)) begin
                w_idx = w_idx - c_IW'(N_PORTS);
            end
            if (in_valid[w_idx[c_GW-1:0]]) begin
                w_sel   = w_idx[c_GW-1:0];
                w_found = 1'b1;
            end
        end
    end

    assign w_ptr_nxt  = (w_sel == c_GW'(N_PORTS - 1)) ? '0 : w_sel + 1'b1;
    assign w_hs       = (r_state == S_XFER) && w_g_valid && out_ready;
    assign w_at_max   = (r_cnt == c_LAST_BYTE);
    assign w_trunc    = w_hs && !w_g_last && w_at_max;
    assign w_drop_end = (r_state == S_DROP) && w_g_valid && w_g_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_found) w_state_nxt = S_XFER;
            S_XFER: begin
                if (w_hs && w_g_last) begin
                    w_state_nxt = c_POST;
                end else if (w_trunc) begin
                    w_state_nxt = S_DROP;
                end
            end
            S_DROP: if (w_drop_end) w_state_nxt = c_POST;
            S_GAP:  if (r_gap == c_GAP_END) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_grant  <= '0;
            r_rr_ptr <= '0;
            r_cnt    <= '0;
            r_gap    <= '0;
            r_trunc  <= 1'b0;
        end else begin
            r_trunc <= w_trunc;
            if (r_state == S_IDLE && w_found) begin
                r_grant  <= w_sel;
                r_rr_ptr <= w_ptr_nxt;
                r_cnt    <= '0;
            end else if (w_hs) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_gap <= (r_state == S_GAP) ? r_gap + 1'b1 : '0;
        end
    end

    always_comb begin
        in_ready  = '0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        case (r_state)
            S_XFER: begin
                in_ready[r_grant] = out_ready;
                out_valid         = w_g_valid;
                out_data          = w_g_valid ? w_g_data : 8'h00;
                out_last          = w_g_valid && (w_g_last || w_at_max);
            end
            S_DROP:  in_ready[r_grant] = 1'b1;
            default: ;
        endcase
    end

    assign grant_id    = r_grant;
    assign trunc_pulse = r_trunc;

endmodule
`default_nettype wire
